// File: rtl/piece_rng_pkg.sv
// Shared constants and types for the piece_rng LFSR piece generator.
package piece_rng_pkg;

  localparam int          WIDTH      = 8;
  localparam logic [7:0]  SEED       = 8'hAD;
  localparam int          NUM_PIECES = 5;
  localparam int          PIECE_W    = 3;

  typedef logic [PIECE_W-1:0] piece_t;
  typedef logic [WIDTH-1:0]   lfsr_state_t;

  // Reduce a state word to a piece index; result always fits in PIECE_W bits
  // because the modulus is at most 2**PIECE_W.
  function automatic piece_t piece_of(input lfsr_state_t s, input int n);
    return piece_t'(s % lfsr_state_t'(n));
  endfunction

endpackage

// File: rtl/piece_rng_cells.sv
// Leaf cells for piece_rng: a per-bit enabled flop with synchronous clear,
// and a 2:1 select.

module dffe (
  output logic q,
  input  logic d,
  input  logic clk,
  input  logic en,
  input  logic clr
);

  // clr has priority over en; both are sampled on the rising edge
  always_ff @(posedge clk) begin
    if (clr)     q <= 1'b0;
    else if (en) q <= d;
  end

endmodule

module mux2In (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/piece_rng.sv
// piece_rng: 8-bit Galois LFSR producing a registered piece index 0..4.
// Built from one dffe + one mux2In per state bit.
// Optional macro PIECE_RNG_STATE_OBS_EN adds the state_obs debug output,
// which mirrors the internal LFSR state combinationally.
module piece_rng #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] SEED       = 8'hAD,
  parameter int               NUM_PIECES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
`ifdef PIECE_RNG_STATE_OBS_EN
  output logic [WIDTH-1:0] state_obs,
`endif
  output logic [2:0]       q
);

  import piece_rng_pkg::*;

  logic [WIDTH-1:0] s;       // LFSR state
  logic [WIDTH-1:0] fb;      // Galois next state
  logic [WIDTH-1:0] ld_val;  // value written on reset/load
  logic [WIDTH-1:0] d;       // per-bit mux output
  logic             sel;     // 1: take ld_val, 0: take fb
  logic             s_en;    // state cells capture this cycle
  logic             q_en;    // a real step happens this cycle
  piece_t           pc;      // piece index of the pre-update state

  // Reset and load share the mux's load leg. A zero seed would lock the
  // LFSR, so it is replaced with SEED.
  assign ld_val = (reset || (seed_in == '0)) ? SEED : seed_in;
  assign sel    = reset | load;
  assign s_en   = reset | load | en;
  // load beats en, so only a bare en advances the output
  assign q_en   = en & ~load;

  // Galois feedback: shift right, XOR every lower tap with the outgoing bit
  genvar i;
  generate
    for (i = 0; i < WIDTH - 1; i++) begin : g_fb
      assign fb[i] = s[i+1] ^ s[0];
    end
  endgenerate
  assign fb[WIDTH-1] = s[0];

  // Per-bit select and state flop; clr unused on state bits since reset
  // loads SEED through the mux instead of clearing
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      mux2In u_mux (
        .in0 (fb[i]),
        .in1 (ld_val[i]),
        .sel (sel),
        .out (d[i])
      );
      dffe u_ff (
        .q   (s[i]),
        .d   (d[i]),
        .clk (clock),
        .en  (s_en),
        .clr (1'b0)
      );
    end
  endgenerate

  // Piece index taken from the current state, so q lags the state by a step
  assign pc = piece_of(s, NUM_PIECES);

  // Output register: cleared by reset, captured only on a real step
  generate
    for (i = 0; i < PIECE_W; i++) begin : g_q
      dffe u_qff (
        .q   (q[i]),
        .d   (pc[i]),
        .clk (clock),
        .en  (q_en),
        .clr (reset)
      );
    end
  endgenerate

`ifdef PIECE_RNG_STATE_OBS_EN
  assign state_obs = s;
`endif

endmodule

// File: tb/tb_piece_rng.sv
// Self-checking bench for piece_rng: directed vector table, a reset/idle
// sequence, then randomized en/load/reset traffic against a reference model.
module tb_piece_rng;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [2:0] q;
`ifdef PIECE_RNG_STATE_OBS_EN
  logic [7:0] state_obs;
`endif

  int total = 0;
  int bad   = 0;

  piece_rng dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .seed_in (seed_in),
`ifdef PIECE_RNG_STATE_OBS_EN
    .state_obs (state_obs),
`endif
    .q       (q)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       en;
    logic [7:0] seed;
    logic [2:0] q;
    logic [7:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input logic e,
                     input logic [7:0] sd, input logic [2:0] eq, input logic [7:0] es);
    vec_t v;
    v.rst = r; v.ld = l; v.en = e; v.seed = sd; v.q = eq; v.st = es;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, sample 1 time unit later
  task automatic cyc(input logic r, input logic l, input logic e, input logic [7:0] sd);
    reset = r; load = l; en = e; seed_in = sd;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [7:0] exp);
`ifdef PIECE_RNG_STATE_OBS_EN
    chk(nm, int'(state_obs), int'(exp));
`else
    if (exp == 8'h00) $display("unexpected zero expectation in %s", nm);
`endif
  endtask

  // Reference model: the LFSR as a right-shifting Galois register whose
  // tap mask is all ones, and the piece as plain integer remainder.
  int ms, mq;

  function automatic int lfsr_next(input int v);
    return (v & 1) ? ((v >> 1) ^ 8'hFF) : (v >> 1);
  endfunction

  task automatic model(input logic r, input logic l, input logic e, input logic [7:0] sd);
    if (r) begin
      ms = 8'hAD; mq = 0;
    end else if (l) begin
      ms = (sd == 0) ? 8'hAD : int'(sd);
    end else if (e) begin
      mq = ms % 5;
      ms = lfsr_next(ms);
    end
  endtask

  initial begin
    // Directed table
    add(1,0,0,8'h00, 0, 8'hAD);
    add(0,0,1,8'h00, 3, 8'hA9);
    add(0,0,1,8'h00, 4, 8'hAB);
    add(0,0,1,8'h00, 1, 8'hAA);
    add(0,0,1,8'h00, 0, 8'h55);
    add(0,0,1,8'h00, 0, 8'hD5);
    add(0,0,1,8'h00, 3, 8'h95);
    add(1,0,0,8'h00, 0, 8'hAD);
    add(0,1,0,8'h00, 0, 8'hAD);   // zero seed guarded
    add(0,1,0,8'h55, 0, 8'h55);
    add(0,0,1,8'h00, 0, 8'hD5);
    add(0,0,1,8'h00, 3, 8'h95);
    add(0,1,1,8'hA9, 3, 8'hA9);   // load beats en, q holds
    add(0,0,1,8'h00, 4, 8'hAB);
    add(0,0,0,8'h00, 4, 8'hAB);   // idle holds
    // Mid-run reset restarts the sequence
    add(1,0,0,8'h00, 0, 8'hAD);
    add(0,0,1,8'h00, 3, 8'hA9);
    add(0,0,1,8'h00, 4, 8'hAB);
    add(0,0,1,8'h00, 1, 8'hAA);
    add(1,0,1,8'h00, 0, 8'hAD);   // reset wins over en
    add(0,0,1,8'h00, 3, 8'hA9);
    add(0,0,1,8'h00, 4, 8'hAB);
    add(0,0,1,8'h00, 1, 8'hAA);
    add(0,0,1,8'h00, 0, 8'h55);
    add(0,0,1,8'h00, 0, 8'hD5);
    add(0,0,1,8'h00, 3, 8'h95);

    #2;
    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].ld, tbl[k].en, tbl[k].seed);
      chk($sformatf("vec%0d_q", k), int'(q), int'(tbl[k].q));
      chk_state($sformatf("vec%0d_state", k), tbl[k].st);
    end

    // Reset followed by 10 idle cycles: nothing moves
    cyc(1,0,0,8'h00);
    for (int k = 0; k < 10; k++) begin
      cyc(0,0,0,8'h3C);
      chk($sformatf("idle%0d_q", k), int'(q), 0);
      chk_state($sformatf("idle%0d_state", k), 8'hAD);
    end

    // Randomized traffic against the model
    cyc(1,0,0,8'h00);
    model(1,0,0,8'h00);
    for (int k = 0; k < 2000; k++) begin
      logic r, l, e;
      logic [7:0] sd;
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 10);
      e  = ($urandom_range(0, 99) < 60);
      sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cyc(r, l, e, sd);
      model(r, l, e, sd);
      chk($sformatf("rnd%0d_q", k), int'(q), mq);
      chk($sformatf("rnd%0d_q_range", k), int'(q <= 3'd4), 1);
`ifdef PIECE_RNG_STATE_OBS_EN
      chk($sformatf("rnd%0d_state", k), int'(state_obs), ms);
      chk($sformatf("rnd%0d_state_nz", k), int'(state_obs != 8'h00), 1);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
